// File: rtl/inst_mem_pipelined.sv
// Instruction memory with a pipelined synchronous read, valid/ready
// handshakes, flush on redirect, a runtime word loader and fault reporting.
module inst_mem_pipelined #(
    parameter int          ADDR_W       = 64,
    parameter int          DEPTH_WORDS  = 64,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] INIT_WORD    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic [ADDR_W-1:0] Inst_Address,
    output logic              Resp_Valid,
    input  logic              Resp_Ready,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] Resp_Address,
    output logic [1:0]        Fault,
    input  logic              Flush,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Address,
    input  logic [31:0]       Load_Data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LAST  = READ_LATENCY - 1;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * 4);

    // Power-on image only; reset leaves the contents alone.
    logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

    logic              v [READ_LATENCY];
    logic [ADDR_W-1:0] a [READ_LATENCY];
    logic [31:0]       d [READ_LATENCY];
    logic [1:0]        f [READ_LATENCY];

    logic        adv;
    logic        accept;
    logic        load_ok;
    logic [1:0]  req_fault;
    logic [31:0] req_data;

    assign adv       = !v[LAST] || Resp_Ready;
    assign Req_Ready = adv && !Load_En && !Flush;
    assign accept    = Req_Valid && Req_Ready;

    assign req_fault = {Inst_Address >= SPAN, Inst_Address[1:0] != 2'b00};
    assign req_data  = (req_fault == 2'b00)
                     ? mem[Inst_Address[IDX_W+1:2]]
                     : INIT_WORD;

    assign load_ok = Load_En && (Load_Address < SPAN);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[Load_Address[IDX_W+1:2]] <= Load_Data;
        end
    end

    // Flush wins over a stall so a redirect never waits on the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                v[i] <= 1'b0;
                a[i] <= '0;
                d[i] <= '0;
                f[i] <= '0;
            end
        end else if (Flush) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                v[i] <= 1'b0;
            end
        end else if (adv) begin
            v[0] <= accept;
            if (accept) begin
                a[0] <= Inst_Address;
                d[0] <= req_data;
                f[0] <= req_fault;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
                d[i] <= d[i-1];
                f[i] <= f[i-1];
            end
        end
    end

    assign Resp_Valid   = v[LAST];
    assign Instruction  = d[LAST];
    assign Resp_Address = a[LAST];
    assign Fault        = f[LAST];

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Directed bench for inst_mem_pipelined: a latency-2 and a latency-3
// instance share one stimulus stream.
module tb_inst_mem_pipelined;

    logic        clk;
    logic        reset;
    logic        Req_Valid;
    logic [63:0] Inst_Address;
    logic        Resp_Ready;
    logic        Flush;
    logic        Load_En;
    logic [63:0] Load_Address;
    logic [31:0] Load_Data;

    logic        rr2, rv2, rr3, rv3;
    logic [31:0] ins2, ins3;
    logic [63:0] ra2, ra3;
    logic [1:0]  ft2, ft3;

    int checks = 0;
    int errors = 0;

    inst_mem_pipelined #(
        .ADDR_W(64), .DEPTH_WORDS(64), .READ_LATENCY(2),
        .INIT_WORD(32'h00000013)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .Req_Valid(Req_Valid), .Req_Ready(rr2),
        .Inst_Address(Inst_Address),
        .Resp_Valid(rv2), .Resp_Ready(Resp_Ready),
        .Instruction(ins2), .Resp_Address(ra2), .Fault(ft2),
        .Flush(Flush), .Load_En(Load_En),
        .Load_Address(Load_Address), .Load_Data(Load_Data)
    );

    inst_mem_pipelined #(
        .ADDR_W(64), .DEPTH_WORDS(64), .READ_LATENCY(3),
        .INIT_WORD(32'h00000013)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .Req_Valid(Req_Valid), .Req_Ready(rr3),
        .Inst_Address(Inst_Address),
        .Resp_Valid(rv3), .Resp_Ready(Resp_Ready),
        .Instruction(ins3), .Resp_Address(ra3), .Fault(ft3),
        .Flush(Flush), .Load_En(Load_En),
        .Load_Address(Load_Address), .Load_Data(Load_Data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        Req_Valid    = 1'b0;
        Inst_Address = '0;
        Resp_Ready   = 1'b1;
        Flush        = 1'b0;
        Load_En      = 1'b0;
        Load_Address = '0;
        Load_Data    = '0;

        #2;
        chk("rst_rv", rv2, 0);
        chk("rst_ins", ins2, 0);
        chk("rst_ft", ft2, 0);
        chk("rst_ra", ra2, 0);

        cyc();
        reset = 1'b1;
        #1 chk("rdy_after_rst", rr2, 1);

        // program load; loader blocks fetches
        cyc();
        Load_En = 1'b1; Load_Address = 64'd0; Load_Data = 32'h00800593;
        Req_Valid = 1'b1; Inst_Address = 64'd0;
        #1 chk("load_blocks", rr2, 0);
        cyc();
        Load_Address = 64'd4; Load_Data = 32'h04b68463;
        cyc();
        Load_En = 1'b0; Inst_Address = 64'd0;
        #1 chk("rdy_fetch", rr2, 1);

        // back-to-back fetches, latency 2
        cyc();
        chk("lat_c1_rv", rv2, 0);
        Inst_Address = 64'd4;
        cyc();
        chk("lat_c2_rv", rv2, 1);
        chk("lat_c2_ins", ins2, 32'h00800593);
        chk("lat_c2_ra", ra2, 0);
        chk("lat_c2_ft", ft2, 0);
        Inst_Address = 64'd6;
        cyc();
        chk("lat_c3_rv", rv2, 1);
        chk("lat_c3_ins", ins2, 32'h04b68463);
        chk("lat_c3_ra", ra2, 4);
        chk("lat_c3_ft", ft2, 0);
        Inst_Address = 64'd256;
        cyc();
        chk("mis_rv", rv2, 1);
        chk("mis_ft", ft2, 2'b01);
        chk("mis_ins", ins2, 32'h00000013);
        chk("mis_ra", ra2, 6);
        Inst_Address = 64'h8000_0000_0000_0000;
        cyc();
        chk("oor_ft", ft2, 2'b10);
        chk("oor_ins", ins2, 32'h00000013);
        chk("oor_ra", ra2, 256);
        Inst_Address = 64'd257;
        cyc();
        chk("hi_ft", ft2, 2'b10);
        chk("hi_ra", ra2, 64'h8000_0000_0000_0000);
        Req_Valid = 1'b0;
        cyc();
        chk("both_ft", ft2, 2'b11);
        chk("both_ins", ins2, 32'h00000013);
        cyc();
        chk("idle_rv", rv2, 0);

        // backpressure
        Resp_Ready = 1'b0; Req_Valid = 1'b1; Inst_Address = 64'd0;
        cyc();
        chk("bp_b_rv", rv2, 0);
        Inst_Address = 64'd4;
        cyc();
        chk("bp_c_rv", rv2, 1);
        chk("bp_c_ins", ins2, 32'h00800593);
        Inst_Address = 64'd8;
        #1 chk("bp_c_rdy", rr2, 0);
        cyc();
        chk("bp_d_rv", rv2, 1);
        chk("bp_d_ins", ins2, 32'h00800593);
        chk("bp_d_ra", ra2, 0);
        chk("bp_d_rdy", rr2, 0);
        Resp_Ready = 1'b1;
        #1 chk("bp_rel_rdy", rr2, 1);
        cyc();
        chk("bp_e_rv", rv2, 1);
        chk("bp_e_ra", ra2, 4);
        chk("bp_e_ins", ins2, 32'h04b68463);
        Req_Valid = 1'b0;
        cyc();
        chk("bp_f_rv", rv2, 1);
        chk("bp_f_ra", ra2, 8);
        chk("bp_f_ins", ins2, 32'h00000013);
        chk("bp_f_ft", ft2, 0);
        cyc();
        chk("bp_g_rv", rv2, 0);
        cyc();

        // flush with two requests in flight on the latency-3 instance
        Req_Valid = 1'b1; Inst_Address = 64'd0;
        cyc();
        Inst_Address = 64'd4;
        cyc();
        chk("fl_j_rv3", rv3, 0);
        Req_Valid = 1'b0; Flush = 1'b1;
        #1 chk("fl_rdy2", rr2, 0);
        chk("fl_rdy3", rr3, 0);
        cyc();
        chk("fl_k_rv2", rv2, 0);
        chk("fl_k_rv3", rv3, 0);
        Flush = 1'b0; Req_Valid = 1'b1; Inst_Address = 64'd8;
        cyc();
        chk("fl_l_rv3", rv3, 0);
        Req_Valid = 1'b0;
        cyc();
        chk("fl_m_rv3", rv3, 0);
        chk("fl_m_rv2", rv2, 1);
        chk("fl_m_ra2", ra2, 8);
        cyc();
        chk("fl_n_rv3", rv3, 1);
        chk("fl_n_ra3", ra3, 8);
        chk("fl_n_ins3", ins3, 32'h00000013);
        chk("fl_n_ft3", ft3, 0);
        cyc();
        chk("fl_o_rv3", rv3, 0);

        // write then fetch the same word next cycle
        Load_En = 1'b1; Load_Address = 64'd12; Load_Data = 32'hFFFFFFFF;
        Req_Valid = 1'b1; Inst_Address = 64'd12;
        #1 chk("ld_rdy", rr2, 0);
        cyc();
        Load_En = 1'b0;
        cyc();
        Req_Valid = 1'b0;
        cyc();
        chk("ld_rv", rv2, 1);
        chk("ld_ins", ins2, 32'hFFFFFFFF);
        chk("ld_ra", ra2, 12);

        // out-of-range write must not alias onto word 0
        Load_En = 1'b1; Load_Address = 64'd256; Load_Data = 32'hDEADBEEF;
        cyc();
        Load_En = 1'b0;

        // asynchronous reset mid-stream
        Req_Valid = 1'b1; Inst_Address = 64'd4;
        cyc();
        Req_Valid = 1'b0;
        cyc();
        chk("ar_pre_rv", rv2, 1);
        chk("ar_pre_ins", ins2, 32'h04b68463);
        #2 reset = 1'b0;
        #1;
        chk("ar_rv", rv2, 0);
        chk("ar_ins", ins2, 0);
        chk("ar_ft", ft2, 0);
        chk("ar_ra", ra2, 0);
        cyc();
        reset = 1'b1;
        Req_Valid = 1'b1; Inst_Address = 64'd0;
        #1 chk("ar_rdy", rr2, 1);
        cyc();
        Req_Valid = 1'b0;
        cyc();
        chk("ar_post_rv", rv2, 1);
        chk("ar_post_ins", ins2, 32'h00800593);
        chk("ar_post_ft", ft2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_pipelined.md
Name: inst_mem_pipelined

Overview:
Parametrised, byte-addressed, little-endian instruction memory with a synchronous read of configurable latency, valid/ready handshakes on request and response, and a word-write loader port. It is the fetch-stage memory for the pipelined core. It replaces the purely combinational ROM and adds:
- backpressure
- flush on redirect
- runtime program loading
- misaligned and out-of-range fault reporting

Parameters:
ADDR_W, 64, width of the byte address on all address ports
DEPTH_WORDS, 64, number of 32-bit words stored; byte span is DEPTH_WORDS*4
READ_LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4
INIT_WORD, 32'h00000013, power-on content of every word and the data returned on a fault (RISC-V NOP)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
Req_Valid  input  1  fetch request present
Req_Ready  output  1  request accepted on this edge when Req_Valid && Req_Ready
Inst_Address  input  ADDR_W  byte address of the fetch
Resp_Valid  output  1  response present
Resp_Ready  input  1  consumer takes the response this edge
Instruction  output  32  fetched word; {byte A+3, A+2, A+1, A}
Resp_Address  output  ADDR_W  address that produced this response
Fault  output  2  bit0 = misaligned, bit1 = out of range
Flush  input  1  discard all in-flight requests
Load_En  input  1  write Load_Data to memory this edge
Load_Address  input  ADDR_W  byte address of the loader write; bits [1:0] ignored
Load_Data  input  32  word to write, little-endian byte placement

Behaviour:
- Storage: DEPTH_WORDS x 32 bits. Every word initialised to INIT_WORD at time zero. Contents are not affected by reset.
- Pipeline: READ_LATENCY stages. Each stage holds valid, address, data and fault. The last stage drives Resp_Valid, Instruction, Resp_Address and Fault.
- Advance condition: adv = !Resp_Valid || Resp_Ready. When adv = 0 the whole pipeline holds and every output stays stable.
- Req_Ready = adv && !Load_En && !Flush (combinational).
- Accepted request:
  - Stage 1 captures address, fault and data on the accepting edge.
  - With no stalls, Resp_Valid rises READ_LATENCY cycles after acceptance.
  - Sustained throughput is one request per cycle.
- Fault, checked at acceptance:
  - Misaligned if Inst_Address[1:0] != 0.
  - Out of range if Inst_Address >= DEPTH_WORDS*4.
  - Both bits may be set together.
  - Any fault: Instruction = INIT_WORD and the memory is not read.
  - A faulted request still produces a response; it is never dropped.
- Flush:
  - On the edge where Flush = 1, every stage valid clears. Resp_Valid is 0 in the next cycle.
  - Flush takes priority over a stall; Resp_Ready is ignored that cycle.
- Loader:
  - When Load_En = 1 the word at Load_Address[ADDR_W-1:2] is written on the edge.
  - An out-of-range write is silently dropped.
  - Loader writes take priority over fetches: Req_Ready is low that cycle.
  - Responses already in flight still drain and keep their old data.
  - A fetch accepted the cycle after a write to the same word returns the new data.
- Reset (reset = 0), asynchronous and immediate:
  - All stage valids = 0, Resp_Valid = 0, Instruction = 0, Resp_Address = 0, Fault = 0.
  - Requests in flight are lost.
  - Memory keeps its contents.
  - Req_Ready = 1 once reset deasserts, provided Load_En and Flush are 0.
- Word assembly is little-endian: Instruction[7:0] is the byte at the word base address.
- Address comparison uses the full ADDR_W width with no truncation, so high address bits set always give out of range.

Test Plan:
- Load 32'h00800593 to addr 0 and 32'h04b68463 to addr 4, then back-to-back fetches of 0 and 4 with Resp_Ready = 1 and READ_LATENCY = 2 -> Resp_Valid high on cycles 2 and 3 after the first acceptance, Instruction = 00800593 then 04b68463, Fault = 0.
- Fetch addr 6 -> Fault = 2'b01, Instruction = 00000013. Fetch addr 256 with DEPTH_WORDS = 64 -> Fault = 2'b10, Instruction = 00000013.
- Hold Resp_Ready = 0 while streaming addresses 0, 4, 8 -> Req_Ready falls once the pipeline is full and outputs hold stable. Release -> responses arrive in order with none lost or duplicated.
- Assert Flush with 2 requests in flight (READ_LATENCY = 3) -> no Resp_Valid for those requests. A fetch of addr 8 issued the cycle after Flush returns normally.
- Hold Load_En = 1 with Req_Valid = 1 -> Req_Ready = 0. Write FFFFFFFF to addr 12, then fetch 12 the next cycle -> Instruction = FFFFFFFF.
- Assert reset low mid-stream, asynchronously between edges -> Resp_Valid, Instruction and Fault go to 0 immediately. After release, fetch addr 0 -> previously loaded data 00800593 is returned.
